// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the 4-bit registered ALU.
//   WIDTH    - operand/result width (fixed at 4 by the alu_inf interface)
//   SEL_W    - opcode width
//   alu_op_e - opcode encoding, 0..7 in listed order
//   alu_compute(a, b, op) - combinational ALU function. The core uses it,
//   and a reference model may call it too. Arithmetic is modulo 2^WIDTH.
//   Carry, borrow and shifted-out bits are dropped.
package alu_pkg;

    localparam int WIDTH = 4;
    localparam int SEL_W = 3;

    typedef enum logic [SEL_W-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_NOT = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } alu_op_e;

    function automatic logic [WIDTH-1:0] alu_compute(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input alu_op_e          op
    );
        logic [WIDTH-1:0] r;
        r = '0;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOT:  r = ~a;
            OP_SHL:  r = {a[WIDTH-2:0], 1'b0};
            OP_SHR:  r = {1'b0, a[WIDTH-1:1]};
            // X/Z on sel lands here. Propagate X so that bad selects are not masked.
            default: r = 'x;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational next-result logic.
//   a      - operand A
//   b      - operand B
//   sel    - operation select (alu_op_e encoding)
//   result - computed value, unregistered
module alu_core
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = alu_compute(a, b, alu_op_e'(sel));
    end

endmodule

// File: rtl/alu_modport.sv
// alu_modport: 4-bit, 8-function ALU with a registered result.
//   clk    - clock, rising edge active
//   reset  - synchronous reset, active-high. It has priority over the op captured on the same edge.
//   A, B   - operands
//   sel    - operation select (alu_op_e encoding)
//   Result - registered result. It updates on the edge that captures A/B/sel.
// There is no handshake. Every non-reset edge loads a new result.
module alu_modport
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] Result
);

    logic [WIDTH-1:0] next_result;

    alu_core u_core (
        .a      (A),
        .b      (B),
        .sel    (sel),
        .result (next_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            Result <= '0;
        end else begin
            Result <= next_result;
        end
    end

endmodule

// File: tb/tb_alu_modport.sv
module tb_alu_modport;

    logic       clk;
    logic       reset;
    logic [3:0] A;
    logic [3:0] B;
    logic [2:0] sel;
    logic [3:0] Result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] sel;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[10];

    alu_modport dut (
        .clk    (clk),
        .reset  (reset),
        .A      (A),
        .B      (B),
        .sel    (sel),
        .Result (Result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] exp);
        checks++;
        if (Result !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, Result, exp);
        end
    endtask

    // Drive the inputs just after an edge. The DUT captures them on the next edge.
    // The check runs 1 time unit after that edge.
    task automatic step(input logic rst, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] s, input string name, input logic [3:0] exp);
        reset = rst;
        A     = a;
        B     = b;
        sel   = s;
        @(posedge clk);
        #1;
        check(name, exp);
    endtask

    logic [3:0] seq_exp[8];

    initial begin
        vecs[0] = '{"add_wrap", 4'hF, 4'h1, 3'b000, 4'h0};
        vecs[1] = '{"add",      4'h5, 4'h6, 3'b000, 4'hB};
        vecs[2] = '{"sub_wrap", 4'h0, 4'h1, 3'b001, 4'hF};
        vecs[3] = '{"sub",      4'h9, 4'h4, 3'b001, 4'h5};
        vecs[4] = '{"and",      4'hC, 4'hA, 3'b010, 4'h8};
        vecs[5] = '{"or",       4'hC, 4'hA, 3'b011, 4'hE};
        vecs[6] = '{"xor",      4'hC, 4'hA, 3'b100, 4'h6};
        vecs[7] = '{"not",      4'hC, 4'hA, 3'b101, 4'h3};
        vecs[8] = '{"shl",      4'h9, 4'h0, 3'b110, 4'h2};
        vecs[9] = '{"shr",      4'h9, 4'h0, 3'b111, 4'h4};

        seq_exp[0] = 4'h9; seq_exp[1] = 4'h3; seq_exp[2] = 4'h2; seq_exp[3] = 4'h7;
        seq_exp[4] = 4'h5; seq_exp[5] = 4'h9; seq_exp[6] = 4'hC; seq_exp[7] = 4'h3;

        reset = 1'b1;
        A     = 4'h7;
        B     = 4'h3;
        sel   = 3'b000;
        #1;

        // Hold reset for 2 edges with a live ADD on the inputs.
        step(1'b1, 4'h7, 4'h3, 3'b000, "reset_edge1", 4'h0);
        step(1'b1, 4'h7, 4'h3, 3'b000, "reset_edge2", 4'h0);
        step(1'b0, 4'h7, 4'h3, 3'b000, "post_reset_add", 4'hA);

        for (int i = 0; i < 10; i++) begin
            step(1'b0, vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].name, vecs[i].exp);
        end

        // Back-to-back ops with a new sel on every edge.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 4'h6, 4'h3, 3'(i), $sformatf("b2b_op%0d", i), seq_exp[i]);
        end

        // Change sel every edge. Reset arrives while op 3 is presented, so that op is dropped.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'h6, 4'h3, 3'(i), $sformatf("pre_rst_op%0d", i), seq_exp[i]);
        end
        step(1'b1, 4'h6, 4'h3, 3'd3, "mid_op_reset", 4'h0);
        for (int i = 3; i < 8; i++) begin
            step(1'b0, 4'h6, 4'h3, 3'(i), $sformatf("resume_op%0d", i), seq_exp[i]);
        end

        // Hold the inputs across edges. Result holds the same value.
        step(1'b0, 4'h5, 4'h6, 3'b000, "hold_a", 4'hB);
        step(1'b0, 4'h5, 4'h6, 3'b000, "hold_b", 4'hB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
